app_iseq_driver: RTL and testbench
==================================

APP_ISEQ_DRIVER -- requirements
Module: app_iseq_driver

Interface
REQ-001 The block SHALL have parameter OUT_WIDTH, default 64: width of the host readback stream; 512 SHALL be a multiple of it, giving BEATS = 512/OUT_WIDTH.
REQ-002 The block SHALL have parameter START_TIMEOUT, default 1024: cycles to wait for processing_iseq after the last instruction is acknowledged.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port host_instr_valid, input, 1: host instruction word available.
REQ-006 Port host_instr_ready, output, 1: host instruction word accepted.
REQ-007 Port host_instr, input, 32: instruction word.
REQ-008 Port host_instr_last, input, 1: marks the final word of a sequence.
REQ-009 Port app_en, output, 1: instruction request to the controller.
REQ-010 Port app_ack, input, 1: controller accepted the instruction.
REQ-011 Port app_instr, output, 32: instruction presented to the controller.
REQ-012 Port iq_full, input, 1: controller instruction queue full.
REQ-013 Port processing_iseq, input, 1: controller executing a sequence.
REQ-014 Port rdback_fifo_empty, input, 1: readback FIFO empty.
REQ-015 Port rdback_fifo_rden, output, 1: readback FIFO pop.
REQ-016 Port rdback_data, input, 512: readback FIFO output, valid the cycle after rdback_fifo_rden.
REQ-017 Port rd_valid, output, 1: readback beat valid.
REQ-018 Port rd_ready, input, 1: host accepts beat.
REQ-019 Port rd_data, output, OUT_WIDTH: readback beat.
REQ-020 Port rd_last, output, 1: final beat of a 512-bit line.
REQ-021 Port busy, output, 1: FSM not in IDLE.
REQ-022 Port start_timeout_err, output, 1: sticky timeout flag, cleared on next sequence start.
REQ-023 Port instr_count, output, 16: instructions acknowledged in the current sequence, saturating at 16'hFFFF.

Function
REQ-024 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-025 In IDLE, a host_instr_valid SHALL move the FSM to ISSUE, clear instr_count and clear start_timeout_err.
REQ-026 In ISSUE, host_instr_ready SHALL be asserted only when app_en is low and iq_full is low; a host word accepted in that cycle SHALL be registered into app_instr with app_en high in the next cycle.
REQ-027 Once asserted, app_en and app_instr SHALL be held stable until the first cycle app_ack is sampled high, regardless of iq_full.
REQ-028 app_en SHALL drop in the cycle after app_ack; a new word SHALL NOT be accepted in the app_ack cycle, giving a minimum of 2 cycles per instruction.
REQ-029 Each app_ack cycle SHALL increment instr_count.
REQ-030 When app_ack acknowledges a word that was flagged host_instr_last, the FSM SHALL go to WAIT_BUSY.
REQ-031 WAIT_BUSY: processing_iseq high SHALL move the FSM to WAIT_DONE; START_TIMEOUT cycles without it SHALL set start_timeout_err and return the FSM to IDLE.
REQ-032 WAIT_DONE: processing_iseq low SHALL return the FSM to IDLE; host_instr_ready SHALL be low in WAIT_BUSY and WAIT_DONE.
REQ-033 The readback drain SHALL run independently of the FSM in all states.
REQ-034 The drain SHALL pulse rdback_fifo_rden for one cycle when its line buffer is empty, no pop is pending and rdback_fifo_empty is low.
REQ-035 The drain SHALL capture rdback_data on the following cycle.
REQ-036 The drain SHALL emit BEATS beats, least-significant OUT_WIDTH slice first.
REQ-037 rd_data SHALL hold stable while rd_valid is high and rd_ready is low.
REQ-038 rd_last SHALL be high only on beat BEATS-1.
REQ-039 A new pop SHALL be allowed in the same cycle the last beat is accepted, so a full FIFO yields at most 1 bubble cycle per line.
REQ-040 rdback_fifo_rden SHALL never assert while rdback_fifo_empty is high.

Reset
REQ-041 While rst is high at a clk edge, the FSM SHALL go to IDLE, the line buffer SHALL empty and any pending pop SHALL be discarded; this also applies mid-sequence and mid-line.
REQ-042 After reset, app_en, host_instr_ready, rdback_fifo_rden, rd_valid, rd_last, busy and start_timeout_err SHALL be 0, and app_instr, rd_data and instr_count SHALL be 0.

Structure
REQ-043 Package softmc_host_pkg SHALL hold the FSM state encoding, the 512 line width and the 32-bit instruction width.
REQ-044 The drain SHALL be sub-module rdback_serializer with ports clk, rst, the FIFO-side signals and the rd_* signals.

Verification
REQ-045 Directed test: a 3-word sequence with app_ack 2 cycles after each app_en -> 3 acks, instr_count=3, FSM goes WAIT_BUSY->WAIT_DONE->IDLE following the processing_iseq pulse.
REQ-046 Directed test: iq_full high before the second word -> host_instr_ready stays 0 and no app_en rises until iq_full falls; with iq_full rising while app_en is high, app_en is held until app_ack.
REQ-047 Directed test: processing_iseq never asserted -> after START_TIMEOUT=1024 cycles start_timeout_err=1 and busy=0; the next sequence clears the flag.
REQ-048 Directed test: FIFO holds 2 lines of 0x00..3F byte patterns, rd_ready=1 -> 16 beats, beat0=0x0706050403020100, rd_last on beats 7 and 15, at most 1 bubble cycle.
REQ-049 Directed test: rd_ready toggling and rst asserted on beat 4 -> rd_data stable while stalled; after reset rd_valid=0, no extra rdback_fifo_rden pulse, and the next line starts at beat0.

Source files
------------

// File: rtl/softmc_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : softmc_host_pkg
// Brief    : Shared widths and FSM state encoding for the host-side
//            instruction sequence driver and its readback drain.
// Revision : 1.0 - initial release
// ============================================================================
package softmc_host_pkg;

  // Width of one readback FIFO line and of one controller instruction word
  localparam int LINE_W  = 512;
  localparam int INSTR_W = 32;

  // Instruction sequence FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } iseq_state_t;

  // Increment that sticks at all-ones so the count never wraps
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage : softmc_host_pkg
`default_nettype wire

// File: rtl/rdback_serializer.sv
`default_nettype none
// ============================================================================
// Module   : rdback_serializer
// Brief    : Pops 512-bit lines from the readback FIFO and replays each one
//            as LINE_W/OUT_WIDTH valid/ready beats, LSB slice first.
// Revision : 1.0 - initial release
// ============================================================================
module rdback_serializer
  import softmc_host_pkg::*;
#(
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdback_fifo_empty,
  output logic                 rdback_fifo_rden,
  input  logic [LINE_W-1:0]    rdback_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic                 rd_last
);

  localparam int BEATS = LINE_W / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [LINE_W-1:0] line_q;
  logic              line_vld_q;
  logic              pop_pend_q;
  logic [BW-1:0]     beat_q;

  logic              beat_take;
  logic              last_take;
  logic              pop;

  // Handshake decode; a pop may overlap the acceptance of the final beat so
  // back-to-back lines lose only the single FIFO read-latency cycle.
  always_comb begin
    beat_take = line_vld_q & rd_ready;
    last_take = beat_take & (beat_q == LAST_BEAT);
    pop       = ~rst & ~pop_pend_q & ~rdback_fifo_empty & (~line_vld_q | last_take);
  end

  // Line buffer: capture the popped line one cycle after the pop, then shift
  // one slice down per accepted beat so the current beat is always at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q     <= '0;
      line_vld_q <= 1'b0;
      pop_pend_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      pop_pend_q <= pop;
      if (pop_pend_q) begin
        line_q     <= rdback_data;
        line_vld_q <= 1'b1;
        beat_q     <= '0;
      end else if (beat_take) begin
        line_q <= line_q >> OUT_WIDTH;
        if (last_take) begin
          line_vld_q <= 1'b0;
          beat_q     <= '0;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  // Output mapping straight from the buffer state
  always_comb begin
    rdback_fifo_rden = pop;
    rd_valid         = line_vld_q;
    rd_data          = line_q[OUT_WIDTH-1:0];
    rd_last          = line_vld_q & (beat_q == LAST_BEAT);
  end

endmodule : rdback_serializer
`default_nettype wire

// File: rtl/app_iseq_driver.sv
`default_nettype none
// ============================================================================
// Module   : app_iseq_driver
// Brief    : Feeds a host instruction stream to the memory controller one
//            word at a time, tracks sequence execution with a start timeout,
//            and drains the readback FIFO to a narrow host stream.
// Revision : 1.0 - initial release
// ============================================================================
module app_iseq_driver
  import softmc_host_pkg::*;
#(
  parameter int OUT_WIDTH     = 64,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_instr_valid,
  output logic                 host_instr_ready,
  input  logic [INSTR_W-1:0]   host_instr,
  input  logic                 host_instr_last,
  output logic                 app_en,
  input  logic                 app_ack,
  output logic [INSTR_W-1:0]   app_instr,
  input  logic                 iq_full,
  input  logic                 processing_iseq,
  input  logic                 rdback_fifo_empty,
  output logic                 rdback_fifo_rden,
  input  logic [LINE_W-1:0]    rdback_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 start_timeout_err,
  output logic [15:0]          instr_count
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);

  iseq_state_t   state_q;
  iseq_state_t   state_d;
  logic          last_q;
  logic [TW-1:0] timer_q;

  logic          accept;
  logic          ack_take;
  logic          seq_start;
  logic          timeout_hit;

  // Next-state and handshake decode
  always_comb begin
    state_d          = state_q;
    host_instr_ready = 1'b0;
    accept           = 1'b0;
    ack_take         = app_en & app_ack;
    seq_start        = 1'b0;
    timeout_hit      = 1'b0;
    busy             = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (host_instr_valid) begin
          seq_start = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Only take a new word once the previous one is fully acknowledged
        host_instr_ready = ~app_en & ~iq_full;
        accept           = host_instr_ready & host_instr_valid;
        if (ack_take && last_q) begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (processing_iseq) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!processing_iseq) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller request register: held until the controller acknowledges it
  always_ff @(posedge clk) begin
    if (rst) begin
      app_en    <= 1'b0;
      app_instr <= '0;
      last_q    <= 1'b0;
    end else if (accept) begin
      app_en    <= 1'b1;
      app_instr <= host_instr;
      last_q    <= host_instr_last;
    end else if (ack_take) begin
      app_en <= 1'b0;
    end
  end

  // Per-sequence status: acknowledged word count and sticky start timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count       <= '0;
      start_timeout_err <= 1'b0;
    end else if (seq_start) begin
      instr_count       <= '0;
      start_timeout_err <= 1'b0;
    end else begin
      if (ack_take) begin
        instr_count <= sat_inc16(instr_count);
      end
      if (timeout_hit) begin
        start_timeout_err <= 1'b1;
      end
    end
  end

  // Cycles spent waiting for the controller to begin executing
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_WAIT_BUSY)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  rdback_serializer #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_rdback_serializer (
    .clk               (clk),
    .rst               (rst),
    .rdback_fifo_empty (rdback_fifo_empty),
    .rdback_fifo_rden  (rdback_fifo_rden),
    .rdback_data       (rdback_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_data           (rd_data),
    .rd_last           (rd_last)
  );

endmodule : app_iseq_driver
`default_nettype wire

// File: tb/tb_app_iseq_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_app_iseq_driver
// Brief    : Self-checking bench for app_iseq_driver with a queue-based FIFO
//            and expected-beat model plus a host/controller sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_app_iseq_driver;

  localparam int OW    = 64;
  localparam int TO    = 1024;
  localparam int BEATS = 512 / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_instr_valid;
  logic          host_instr_ready;
  logic [31:0]   host_instr;
  logic          host_instr_last;
  logic          app_en;
  logic          app_ack;
  logic [31:0]   app_instr;
  logic          iq_full;
  logic          processing_iseq;
  logic          rdback_fifo_empty = 1'b1;
  logic          rdback_fifo_rden;
  logic [511:0]  rdback_data = '0;
  logic          rd_valid;
  logic          rd_ready;
  logic [OW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          start_timeout_err;
  logic [15:0]   instr_count;

  int errors = 0;
  int checks = 0;

  logic [511:0] fifo_q[$];
  logic [511:0] push_q[$];
  logic [63:0]  exp_q[$];
  logic [63:0]  acc_dat[$];
  int           acc_cyc[$];
  int           pops = 0;
  int           pushes = 0;
  int           mon_idx = 0;
  int           cyc = 0;
  logic         stall_q = 1'b0;
  logic [63:0]  stall_data = '0;
  logic [63:0]  mon_e;

  always #5 clk = ~clk;

  app_iseq_driver #(
    .OUT_WIDTH     (OW),
    .START_TIMEOUT (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .host_instr_valid  (host_instr_valid),
    .host_instr_ready  (host_instr_ready),
    .host_instr        (host_instr),
    .host_instr_last   (host_instr_last),
    .app_en            (app_en),
    .app_ack           (app_ack),
    .app_instr         (app_instr),
    .iq_full           (iq_full),
    .processing_iseq   (processing_iseq),
    .rdback_fifo_empty (rdback_fifo_empty),
    .rdback_fifo_rden  (rdback_fifo_rden),
    .rdback_data       (rdback_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_data           (rd_data),
    .rd_last           (rd_last),
    .busy              (busy),
    .start_timeout_err (start_timeout_err),
    .instr_count       (instr_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue a line into the FIFO model and its slices into the expected stream
  task automatic push_line(input logic [511:0] l);
    push_q.push_back(l);
    pushes++;
    for (int b = 0; b < BEATS; b++) exp_q.push_back(l[b*OW +: OW]);
  endtask

  function automatic logic [511:0] byte_pattern();
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[i*8 +: 8] = 8'(i);
    return p;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // FIFO model: data appears the cycle after a pop
  always @(posedge clk) begin
    if (rdback_fifo_rden && fifo_q.size() > 0) begin
      rdback_data <= fifo_q.pop_front();
      pops++;
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    rdback_fifo_empty <= (fifo_q.size() == 0);
  end

  // Readback monitor: beat order, rd_last position, stall stability, pop legality
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_idx = 0;
      stall_q = 1'b0;
    end else begin
      if (rdback_fifo_rden) chk("rden_while_empty", 64'(rdback_fifo_empty), 64'd0);
      if (stall_q && rd_valid) chk("rd_hold", rd_data, stall_data);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", rd_data, mon_e);
        end
        chk("rd_last", 64'(rd_last), 64'(mon_idx == BEATS - 1));
        acc_cyc.push_back(cyc);
        acc_dat.push_back(rd_data);
        mon_idx = (mon_idx == BEATS - 1) ? 0 : mon_idx + 1;
      end else if (!rd_valid) begin
        chk("rd_last_idle", 64'(rd_last), 64'd0);
      end
      stall_q    = rd_valid && !rd_ready;
      stall_data = rd_data;
    end
  end

  // Host + controller model for one sequence of n words.
  // fmode: 0 no back-pressure, 1 random iq_full, 2 iq_full held around word 1
  task automatic run_seq(input int n, input int dmin, input int dmax, input int fmode);
    logic [31:0] words[$];
    logic [31:0] cur = '0;
    int idx = 0, acks = 0, ecyc = 0, cnt = 0, dly, hold = 0;
    bit acc, ackd, pend = 1'b0;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    dly = int'($urandom_range(dmax, dmin));
    while (acks < n && cnt < 500) begin
      host_instr_valid = (idx < n);
      host_instr       = (idx < n) ? words[idx] : 32'h0;
      host_instr_last  = (idx == n - 1);
      case (fmode)
        1: iq_full = 1'($urandom_range(1, 0));
        2: begin
          iq_full = pend || (idx == 1 && hold < 4);
          if (idx == 1 && !pend) hold++;
        end
        default: iq_full = 1'b0;
      endcase
      ackd    = pend && (ecyc >= dly);
      app_ack = ackd;
      #1;
      acc = host_instr_ready && host_instr_valid;
      chk("ready_rule", 64'(host_instr_ready && (app_en || iq_full)), 64'd0);
      @(posedge clk);
      #1;
      cnt++;
      if (acc) begin
        chk("app_en_rise", 64'(app_en), 64'd1);
        chk("app_instr", 64'(app_instr), 64'(words[idx]));
        cur  = words[idx];
        idx++;
        pend = 1'b1;
        ecyc = 0;
        dly  = int'($urandom_range(dmax, dmin));
      end else if (ackd) begin
        acks++;
        pend = 1'b0;
        chk("app_en_drop", 64'(app_en), 64'd0);
        chk("instr_count", 64'(instr_count), 64'(acks));
      end else if (pend) begin
        ecyc++;
        chk("app_en_hold", 64'(app_en), 64'd1);
        chk("app_instr_hold", 64'(app_instr), 64'(cur));
      end else begin
        chk("app_en_idle", 64'(app_en), 64'd0);
      end
    end
    host_instr_valid = 1'b0;
    host_instr_last  = 1'b0;
    app_ack          = 1'b0;
    iq_full          = 1'b0;
    chk("seq_acks", 64'(acks), 64'(n));
  endtask

  // Controller runs the sequence briefly, then the FSM must return to idle
  task automatic finish_seq();
    chk("busy_wait_busy", 64'(busy), 64'd1);
    processing_iseq = 1'b1;
    step();
    chk("busy_wait_done", 64'(busy), 64'd1);
    repeat (2) step();
    processing_iseq = 1'b0;
    step();
    chk("busy_back_idle", 64'(busy), 64'd0);
  endtask

  task automatic drain(input int budget, input bit rnd);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      rd_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      step();
      c++;
    end
    rd_ready = 1'b1;
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int bub;
    rst = 1'b1;
    host_instr_valid = 1'b0;
    host_instr = '0;
    host_instr_last = 1'b0;
    app_ack = 1'b0;
    iq_full = 1'b0;
    processing_iseq = 1'b0;
    rd_ready = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_app_en", 64'(app_en), 64'd0);
    chk("rst_ready", 64'(host_instr_ready), 64'd0);
    chk("rst_rden", 64'(rdback_fifo_rden), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(start_timeout_err), 64'd0);
    chk("rst_app_instr", 64'(app_instr), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_instr_count", 64'(instr_count), 64'd0);
    rst = 1'b0;
    rd_ready = 1'b1;
    step();

    // Three words, ack two cycles into each request, then a processing pulse
    run_seq(3, 2, 2, 0);
    chk("count_after_3", 64'(instr_count), 64'd3);
    host_instr_valid = 1'b1;
    #1;
    chk("ready_low_wait_busy", 64'(host_instr_ready), 64'd0);
    host_instr_valid = 1'b0;
    finish_seq();

    // Queue-full back-pressure: directed, then randomized
    run_seq(4, 0, 3, 2);
    finish_seq();
    run_seq(6, 0, 3, 1);
    chk("count_after_6", 64'(instr_count), 64'd6);
    finish_seq();

    // Start timeout: controller never reports processing
    run_seq(2, 1, 1, 0);
    chk("busy_before_timeout", 64'(busy), 64'd1);
    c = 0;
    while (busy && c < TO + 100) begin
      step();
      c++;
    end
    chk("timeout_cycles", 64'(c), 64'(TO));
    chk("timeout_err_set", 64'(start_timeout_err), 64'd1);
    chk("timeout_busy", 64'(busy), 64'd0);
    run_seq(1, 0, 0, 0);
    chk("timeout_err_cleared", 64'(start_timeout_err), 64'd0);
    chk("count_after_1", 64'(instr_count), 64'd1);
    finish_seq();

    // Two byte-pattern lines with the host always ready
    acc_cyc.delete();
    acc_dat.delete();
    push_line(byte_pattern());
    push_line(byte_pattern());
    drain(200, 1'b0);
    chk("two_line_beats", 64'(acc_dat.size()), 64'd16);
    if (acc_dat.size() >= 16) begin
      chk("beat0_value", acc_dat[0], 64'h0706050403020100);
      chk("beat8_value", acc_dat[8], 64'h0706050403020100);
      bub = acc_cyc[15] - acc_cyc[0] - 15;
      chk("bubble_le_1", 64'(bub <= 1), 64'd1);
    end

    // Random lines with random host back-pressure
    for (int i = 0; i < 3; i++) push_line(rand_line());
    drain(600, 1'b1);

    // Reset on beat 4 of a line
    push_line(rand_line());
    c = 0;
    while (!(rd_valid && mon_idx == 4) && c < 200) begin
      rd_ready = 1'($urandom_range(1, 0));
      step();
      c++;
    end
    chk("reached_beat4", 64'(rd_valid && mon_idx == 4), 64'd1);
    rd_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_rd_last", 64'(rd_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rd_ready = 1'b1;
    repeat (4) step();
    chk("no_extra_pop", 64'(pops), 64'(pushes));
    chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);
    acc_dat.delete();
    push_line(byte_pattern());
    drain(100, 1'b0);
    chk("post_rst_beats", 64'(acc_dat.size()), 64'd8);
    if (acc_dat.size() > 0) chk("post_rst_beat0", acc_dat[0], 64'h0706050403020100);
    chk("final_pops", 64'(pops), 64'(pushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_app_iseq_driver
`default_nettype wire
